// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader.
// Holds the loader FSM encoding and protocol reply bytes.
package uart_boot_pkg;

  typedef enum logic [3:0] {
    S_WAIT_CMD,
    S_RX_WORD,
    S_WRITE,
    S_RX_CSUM,
    S_ACK,
    S_ACK_W,
    S_NAK,
    S_NAK_W,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_LAT,
    S_DUMP_TX
  } state_t;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  function automatic int bytes_per_word(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_boot_loader_p_uart_rx_tx.sv
// 8N1 UART receiver and transmitter, CLK_DIV clocks per bit.
// All timing counts only enabled clocks, so ena stretches the line rate.
module uart_rx_tx #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  input  logic       rx_en,
  output logic       byte_valid,
  output logic       framing_err,
  output logic [7:0] byte_data,
  input  logic       send,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic          r_rx_act;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          r_rx_bv, r_rx_fe;

  logic [9:0]    r_tx_sh;
  logic          r_tx_busy;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;

  // Receiver: sync rx, find start edge, sample mid-bit, check stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_act <= 1'b0;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
      r_rx_bv  <= 1'b0;
      r_rx_fe  <= 1'b0;
    end else if (ena) begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      r_rx_bv <= 1'b0;
      r_rx_fe <= 1'b0;
      if (!r_rx_act) begin
        if (rx_en && r_rx_s3 && !r_rx_s2) begin
          r_rx_act <= 1'b1;
          r_rx_cnt <= HALF_M1;
          r_rx_bit <= '0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - CW'(1);
      end else begin
        r_rx_cnt <= DIV_M1;
        if (r_rx_bit == 4'd0) begin
          if (r_rx_s2) r_rx_act <= 1'b0;
          r_rx_bit <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_act <= 1'b0;
          if (r_rx_s2) r_rx_bv <= 1'b1;
          else r_rx_fe <= 1'b1;
        end else begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 4'd1;
        end
      end
    end
  end

  // Transmitter: load a full frame on send, shift it out LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sh   <= '1;
      r_tx_busy <= 1'b0;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
    end else if (ena) begin
      if (!r_tx_busy) begin
        if (send) begin
          r_tx_sh   <= {1'b1, tx_data, 1'b0};
          r_tx_busy <= 1'b1;
          r_tx_cnt  <= DIV_M1;
          r_tx_bit  <= '0;
        end
      end else if (r_tx_cnt != '0) begin
        r_tx_cnt <= r_tx_cnt - CW'(1);
      end else if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
      end else begin
        r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
        r_tx_bit <= r_tx_bit + 4'd1;
        r_tx_cnt <= DIV_M1;
      end
    end
  end

  assign byte_valid  = r_rx_bv;
  assign framing_err = r_rx_fe;
  assign byte_data   = r_rx_sh;
  assign busy        = r_tx_busy;
  assign tx          = r_tx_sh[0];

endmodule

// File: rtl/uart_boot_loader_p.sv
// UART boot loader: uploads a checksummed RAM image, releases the CPU,
// and can dump RAM back over tx on command or scan_memory request.
module uart_boot_loader_p
  import uart_boot_pkg::*;
#(
  parameter int         ADDR_W     = 6,
  parameter int         DATA_W     = 16,
  parameter int         CLK_DIV    = 868,
  parameter logic [7:0] CMD_UPLOAD = 8'h55,
  parameter logic [7:0] CMD_DUMP   = 8'h44
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              rx,
  output logic              tx,
  input  logic              scan_memory,
  output logic              boot,
  input  logic [DATA_W-1:0] ram_out,
  output logic              ram_rw,
  output logic              ram_enable,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_in
);

  localparam int BPW = bytes_per_word(DATA_W);
  localparam int SW = BPW * 8;
  localparam logic [2:0] BPW_N = 3'(BPW);
  localparam logic [2:0] BPW_M1 = 3'(BPW - 1);

  state_t            r_state, w_nx;
  logic [ADDR_W-1:0] r_adr;
  logic [SW-1:0]     r_shift;
  logic [7:0]        r_csum;
  logic [2:0]        r_bcnt;
  logic              r_from_run;
  logic              r_scan_d;

  logic       w_bv, w_fe, w_busy;
  logic [7:0] w_byte, w_txb;
  logic       w_send, w_rx_en;
  logic       w_start_up, w_start_dump;
  logic       w_take, w_inc, w_ld, w_pop, w_clr;
  logic       w_last, w_scan_rise, w_csum_ok;

  assign w_last      = &r_adr;
  assign w_scan_rise = scan_memory & ~r_scan_d;
  assign w_csum_ok   = (w_byte == 8'(~r_csum + 8'd1));

  uart_rx_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rx         (rx),
    .rx_en      (w_rx_en),
    .byte_valid (w_bv),
    .framing_err(w_fe),
    .byte_data  (w_byte),
    .send       (w_send),
    .tx_data    (w_txb),
    .busy       (w_busy),
    .tx         (tx)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT_CMD;
    else if (ena) r_state <= w_nx;
  end

  // Next state plus datapath and UART control strobes.
  always_comb begin
    w_nx         = r_state;
    w_send       = 1'b0;
    w_txb        = 8'h00;
    w_rx_en      = 1'b1;
    w_start_up   = 1'b0;
    w_start_dump = 1'b0;
    w_take       = 1'b0;
    w_inc        = 1'b0;
    w_ld         = 1'b0;
    w_pop        = 1'b0;
    w_clr        = 1'b0;
    unique case (r_state)
      S_WAIT_CMD: begin
        if (w_fe) begin
          w_nx = S_NAK;
        end else if (w_bv && w_byte == CMD_UPLOAD) begin
          w_nx       = S_RX_WORD;
          w_start_up = 1'b1;
        end else if (w_bv && w_byte == CMD_DUMP) begin
          w_nx         = S_DUMP_RD;
          w_start_dump = 1'b1;
        end
      end
      S_RX_WORD: begin
        if (w_fe) begin
          w_nx = S_NAK;
        end else if (w_bv) begin
          w_take = 1'b1;
          if (r_bcnt == BPW_M1) w_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_nx = S_RX_CSUM;
        end else begin
          w_inc = 1'b1;
          w_nx  = S_RX_WORD;
        end
      end
      S_RX_CSUM: begin
        if (w_fe) w_nx = S_NAK;
        else if (w_bv) w_nx = w_csum_ok ? S_ACK : S_NAK;
      end
      S_ACK: begin
        if (!w_busy) begin
          w_send = 1'b1;
          w_txb  = ACK_BYTE;
          w_nx   = S_ACK_W;
        end
      end
      S_ACK_W: begin
        if (!w_busy) w_nx = S_RUN;
      end
      S_NAK: begin
        if (!w_busy) begin
          w_send = 1'b1;
          w_txb  = NAK_BYTE;
          w_nx   = S_NAK_W;
        end
      end
      S_NAK_W: begin
        if (!w_busy) begin
          w_clr = 1'b1;
          w_nx  = S_WAIT_CMD;
        end
      end
      S_RUN: begin
        if (w_bv && w_byte == CMD_UPLOAD) begin
          w_nx       = S_RX_WORD;
          w_start_up = 1'b1;
        end else if (w_scan_rise || (w_bv && w_byte == CMD_DUMP)) begin
          w_nx         = S_DUMP_RD;
          w_start_dump = 1'b1;
        end
      end
      S_DUMP_RD: begin
        w_rx_en = 1'b0;
        w_nx    = S_DUMP_LAT;
      end
      S_DUMP_LAT: begin
        w_rx_en = 1'b0;
        w_ld    = 1'b1;
        w_nx    = S_DUMP_TX;
      end
      S_DUMP_TX: begin
        w_rx_en = 1'b0;
        if (!w_busy) begin
          if (r_bcnt == BPW_N) begin
            if (w_last) begin
              w_nx = r_from_run ? S_RUN : S_WAIT_CMD;
            end else begin
              w_inc = 1'b1;
              w_nx  = S_DUMP_RD;
            end
          end else begin
            w_send = 1'b1;
            w_txb  = r_shift[SW-1 -: 8];
            w_pop  = 1'b1;
          end
        end
      end
      default: w_nx = S_WAIT_CMD;
    endcase
  end

  // Address, word shifter, byte counter and checksum datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr      <= '0;
      r_shift    <= '0;
      r_csum     <= '0;
      r_bcnt     <= '0;
      r_from_run <= 1'b0;
      r_scan_d   <= 1'b0;
    end else if (ena) begin
      r_scan_d <= scan_memory;
      if (w_start_up) begin
        r_adr  <= '0;
        r_csum <= '0;
        r_bcnt <= '0;
      end
      if (w_start_dump) begin
        r_adr      <= '0;
        r_from_run <= (r_state == S_RUN);
      end
      if (w_take) begin
        r_shift <= SW'({r_shift, w_byte});
        r_csum  <= r_csum + w_byte;
        r_bcnt  <= (r_bcnt == BPW_M1) ? 3'd0 : r_bcnt + 3'd1;
      end
      if (w_inc) r_adr <= r_adr + ADDR_W'(1);
      if (w_ld) begin
        r_shift <= SW'(ram_out);
        r_bcnt  <= '0;
      end
      if (w_pop) begin
        r_shift <= r_shift << 8;
        r_bcnt  <= r_bcnt + 3'd1;
      end
      if (w_clr) r_csum <= '0;
    end
  end

  assign boot       = (r_state != S_RUN);
  assign ram_enable = ena & ((r_state == S_WRITE) | (r_state == S_DUMP_RD));
  assign ram_rw     = (r_state == S_WRITE);
  assign ram_adr    = r_adr;
  assign ram_in     = (r_state == S_WRITE) ? r_shift[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_uart_boot_loader_p.sv
// Scoreboard bench for uart_boot_loader_p with a small RAM and UART host.
// Expected tx bytes and RAM writes are queued when stimulus is issued.
module tb_uart_boot_loader_p;

  localparam int AW = 2;
  localparam int DW = 12;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          rx = 1'b1;
  logic          scan_memory = 1'b0;
  logic          tx, boot, ram_rw, ram_enable;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out = '0;
  logic [DW-1:0] mem[4] = '{default: '0};

  logic [7:0]       exp_tx[$];
  logic [AW+DW-1:0] exp_wr[$];
  int               n_tests = 0;
  int               n_fail = 0;
  logic             boot_at_stop = 1'b0;

  int         model_mem[4] = '{default: 0};
  bit         model_run = 1'b0;
  logic [7:0] up_hi[4];
  logic [7:0] up_lo[4];

  always #5 clk = ~clk;

  uart_boot_loader_p #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .CLK_DIV(CD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rx         (rx),
    .tx         (tx),
    .scan_memory(scan_memory),
    .boot       (boot),
    .ram_out    (ram_out),
    .ram_rw     (ram_rw),
    .ram_enable (ram_enable),
    .ram_adr    (ram_adr),
    .ram_in     (ram_in)
  );

  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_rw) mem[ram_adr] <= ram_in;
      else ram_out <= mem[ram_adr];
    end
  end

  always @(negedge clk) begin
    if (rst_n && ram_enable && ram_rw) begin
      n_tests++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL ram_write: got adr %0d data %03h, none expected", ram_adr, ram_in);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_wr.pop_front();
        if ({ram_adr, ram_in} !== e) begin
          n_fail++;
          $display("FAIL ram_write: got adr %0d data %03h, expected adr %0d data %03h",
                   ram_adr, ram_in, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    logic [9:0] f;
    logic [7:0] e;
    int k;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        k = 0;
        for (int b = 0; b < 10; b++) begin
          while (k < CD * b + CD / 2) begin
            @(posedge clk);
            if (ena) k++;
          end
          @(negedge clk);
          f[b] = tx;
        end
        boot_at_stop = boot;
        n_tests++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL tx_byte: got %02h, none expected", f[8:1]);
        end else begin
          e = exp_tx.pop_front();
          if (f[8:1] !== e || f[9] !== 1'b1 || f[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_byte: got %02h (start %b stop %b), expected %02h",
                     f[8:1], f[0], f[9], e);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic en_cycles(input int n);
    int c;
    c = 0;
    while (c < n) begin
      @(posedge clk);
      if (ena) c++;
    end
    #1;
  endtask

  task automatic uart_send(input logic [7:0] b, input bit bad_stop);
    logic [9:0] f;
    f = {~bad_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      en_cycles(CD);
    end
    rx = 1'b1;
  endtask

  task automatic send_stalled(input logic [7:0] b);
    fork
      uart_send(b, 1'b0);
      begin
        repeat (CD * 3) @(posedge clk);
        #1 ena = 1'b0;
        repeat (20) @(posedge clk);
        #1 ena = 1'b1;
      end
    join
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && c < 4000) begin
      @(posedge clk);
      c++;
    end
    n_tests++;
    if (exp_tx.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d tx and %0d writes pending, expected 0",
               exp_tx.size(), exp_wr.size());
      exp_tx.delete();
      exp_wr.delete();
    end
    en_cycles(8);
  endtask

  task automatic upload(input logic [7:0] corrupt, input int stall_byte);
    int sum;
    logic [15:0] w16;
    logic [7:0] cs;
    uart_send(8'h55, 1'b0);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      w16 = {up_hi[i], up_lo[i]};
      exp_wr.push_back({AW'(i), w16[DW-1:0]});
      model_mem[i] = int'(w16) % 4096;
      sum = sum + int'(up_hi[i]) + int'(up_lo[i]);
      if (stall_byte == 2 * i) send_stalled(up_hi[i]);
      else uart_send(up_hi[i], 1'b0);
      if (stall_byte == 2 * i + 1) send_stalled(up_lo[i]);
      else uart_send(up_lo[i], 1'b0);
    end
    cs = 8'((256 - sum % 256) % 256);
    exp_tx.push_back(corrupt == 8'h00 ? 8'h06 : 8'h15);
    uart_send(cs ^ corrupt, 1'b0);
    wait_drain();
    model_run = (corrupt == 8'h00);
    if (model_run) check("ack_boot_at_stop", 32'(boot_at_stop), 32'd1);
    check("boot_after_upload", 32'(boot), 32'(!model_run));
  endtask

  task automatic push_dump();
    logic [15:0] w16;
    for (int i = 0; i < 4; i++) begin
      w16 = 16'(model_mem[i]);
      exp_tx.push_back(w16[15:8]);
      exp_tx.push_back(w16[7:0]);
    end
  endtask

  task automatic cmd_dump();
    push_dump();
    uart_send(8'h44, 1'b0);
    wait_drain();
    check("boot_after_cmd_dump", 32'(boot), 32'(!model_run));
  endtask

  task automatic scan_pulse();
    if (model_run) push_dump();
    scan_memory = 1'b1;
    en_cycles(3);
    check("boot_during_scan", 32'(boot), 32'(1'b1));
    scan_memory = 1'b0;
    wait_drain();
    en_cycles(60);
    check("boot_after_scan", 32'(boot), 32'(!model_run));
  endtask

  task automatic set_directed();
    up_hi = '{8'h0A, 8'h01, 8'h0F, 8'h00};
    up_lo = '{8'hBC, 8'h23, 8'hFF, 8'h00};
  endtask

  initial begin
    int op;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_boot", 32'(boot), 32'd1);
    check("rst_ram_enable", 32'(ram_enable), 32'd0);
    check("rst_ram_rw", 32'(ram_rw), 32'd0);
    check("rst_ram_adr", 32'(ram_adr), 32'd0);
    check("rst_ram_in", 32'(ram_in), 32'd0);
    rst_n = 1'b1;
    en_cycles(4);

    set_directed();
    upload(8'h00, -1);
    upload(8'h11, -1);
    upload(8'h00, -1);

    scan_pulse();

    exp_wr.push_back({AW'(0), 12'hABC});
    model_mem[0] = 12'hABC;
    uart_send(8'h55, 1'b0);
    uart_send(8'h0A, 1'b0);
    uart_send(8'hBC, 1'b0);
    rx = 1'b0;
    en_cycles(CD);
    rx = 1'b1;
    en_cycles(CD);
    rx = 1'b0;
    en_cycles(2);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_boot", 32'(boot), 32'd1);
    check("midrst_ram_enable", 32'(ram_enable), 32'd0);
    rx = 1'b1;
    en_cycles(3);
    rst_n = 1'b1;
    model_run = 1'b0;
    en_cycles(4);
    wait_drain();
    cmd_dump();

    uart_send(8'h55, 1'b0);
    uart_send(8'h0A, 1'b0);
    exp_tx.push_back(8'h15);
    uart_send(8'h5A, 1'b1);
    wait_drain();
    check("boot_after_framing", 32'(boot), 32'd1);
    model_run = 1'b0;

    up_hi = '{8'h0A, 8'h01, 8'h0F, 8'h00};
    up_lo = '{8'hBC, 8'h23, 8'hFF, 8'h00};
    upload(8'h00, 3);
    cmd_dump();

    for (int r = 0; r < 10; r++) begin
      op = int'($urandom_range(0, 3));
      if (op <= 1) begin
        for (int i = 0; i < 4; i++) begin
          up_hi[i] = 8'($urandom);
          up_lo[i] = 8'($urandom);
        end
        upload(op == 0 ? 8'h00 : 8'($urandom_range(1, 255)), -1);
      end else if (op == 2) begin
        cmd_dump();
      end else begin
        scan_pulse();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
